// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl
//   SPI slave frame controller (mode 0, MSB first) running in the system clk
//   domain. A frame is an ADDR_W-bit address, one R/W bit (1 = read) and then
//   one or more DATA_W-bit words. The block only issues single-cycle control
//   strobes; the shift register, address latch and data memory live outside.
//
// Parameters
//   ADDR_W       address bits per header
//   DATA_W       bits per data word
//   SYNC_STAGES  synchroniser depth for sclk_pin / cs_pin (must be >= 2)
//   BURST_EN     1: words continue while CS is low, 0: one word per frame
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sclk_pin    raw SPI clock
//   cs_pin      raw chip select, active low
//   r_or_w      LSB of the external shift register (R/W bit after the header)
//   shift_en    pulse: shift MOSI into the shift register
//   miso_shift  pulse: advance the MISO output bit
//   addr_wr     pulse: latch the address from the shift register
//   s_r         pulse: parallel-load read data into the shift register
//   dm_wr       pulse: write the shift register to data memory
//   addr_inc    pulse: increment the address latch
//   miso_en     level: drive MISO
//   frame_err   pulse: frame aborted mid-word
module spi_frame_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BURST_EN    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic r_or_w,
    output logic shift_en,
    output logic miso_shift,
    output logic addr_wr,
    output logic s_r,
    output logic dm_wr,
    output logic addr_inc,
    output logic miso_en,
    output logic frame_err
);

    localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WORD_FULL = CNT_W'(DATA_W);

    typedef enum logic [3:0] {
        IDLE,
        HEADER,
        HDR_WAIT,
        HDR_DONE,
        RD_WAIT,
        RD_LOAD,
        READ,
        RD_NEXT,
        WRITE,
        WR_DONE,
        WR_INC,
        DONE
    } state_t;

    // ---------------- pin synchronisers ----------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_hist;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   rise;
    logic                   fall;

    // cs path resets high so a reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_hist <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_hist;
    assign fall   = ~sclk_s & sclk_hist;

    // ---------------- frame FSM ----------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             shift_en_nxt;
    logic             miso_shift_nxt;
    logic             addr_wr_nxt;
    logic             s_r_nxt;
    logic             dm_wr_nxt;
    logic             addr_inc_nxt;
    logic             miso_en_nxt;
    logic             frame_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_en   <= 1'b0;
            miso_shift <= 1'b0;
            addr_wr    <= 1'b0;
            s_r        <= 1'b0;
            dm_wr      <= 1'b0;
            addr_inc   <= 1'b0;
            miso_en    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift_en   <= shift_en_nxt;
            miso_shift <= miso_shift_nxt;
            addr_wr    <= addr_wr_nxt;
            s_r        <= s_r_nxt;
            dm_wr      <= dm_wr_nxt;
            addr_inc   <= addr_inc_nxt;
            miso_en    <= miso_en_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shift_en_nxt   = 1'b0;
        miso_shift_nxt = 1'b0;
        addr_wr_nxt    = 1'b0;
        s_r_nxt        = 1'b0;
        dm_wr_nxt      = 1'b0;
        addr_inc_nxt   = 1'b0;
        miso_en_nxt    = miso_en;
        frame_err_nxt  = 1'b0;

        if (cs_s) begin
            // CS release wins over any sclk edge seen in the same cycle.
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            miso_en_nxt   = 1'b0;
            frame_err_nxt = ((state == HEADER) || (state == READ) || (state == WRITE))
                            && (cnt != '0);
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    state_nxt = HEADER;
                end
                HEADER: begin
                    if (rise) begin
                        shift_en_nxt = 1'b1;
                        cnt_nxt      = cnt + CNT_W'(1);
                        if (cnt == HDR_LAST) begin
                            state_nxt = HDR_WAIT;
                        end
                    end
                end
                // One spare cycle lets the last header shift land before r_or_w is used.
                HDR_WAIT: state_nxt = HDR_DONE;
                HDR_DONE: begin
                    addr_wr_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = r_or_w ? RD_WAIT : WRITE;
                end
                // Gives the memory one cycle with the new address before the load.
                RD_WAIT: state_nxt = RD_LOAD;
                RD_LOAD: begin
                    s_r_nxt     = 1'b1;
                    miso_en_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = READ;
                end
                READ: begin
                    if (rise) begin
                        shift_en_nxt = 1'b1;
                        cnt_nxt      = cnt + CNT_W'(1);
                        if (cnt == WORD_LAST) begin
                            state_nxt = (BURST_EN != 0) ? RD_NEXT : DONE;
                        end
                    end else if (fall && (cnt != '0) && (cnt < WORD_FULL)) begin
                        // The first bit is already on MISO after s_r; only bits 2..N advance.
                        miso_shift_nxt = 1'b1;
                    end
                end
                RD_NEXT: begin
                    addr_inc_nxt = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = RD_WAIT;
                end
                WRITE: begin
                    // Wait one cycle after the last rise so the final shift has landed.
                    if (cnt == WORD_FULL) begin
                        state_nxt = WR_DONE;
                    end else if (rise) begin
                        shift_en_nxt = 1'b1;
                        cnt_nxt      = cnt + CNT_W'(1);
                    end
                end
                WR_DONE: begin
                    dm_wr_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (BURST_EN != 0) ? WR_INC : DONE;
                end
                WR_INC: begin
                    addr_inc_nxt = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = WRITE;
                end
                DONE: begin
                    cnt_nxt = '0;
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl
//   Scoreboard bench for spi_frame_ctrl. Two instances share the SPI pins:
//   u_burst (BURST_EN=1) and u_single (BURST_EN=0). Stimulus tasks drive pin
//   edges and push the strobes each edge must cause (kind + cycle) into a
//   per-instance queue; a negedge monitor pops and compares every strobe the
//   DUTs present, and flags expected strobes that never appeared.
//   Pins are driven 1 ns after a clk edge at cycle n; a rise/fall flag then
//   appears in cycle R = n + SYNC_STAGES, and registered strobes at R + k.
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = SYNC_STAGES + 8;

    localparam int K_SHIFT  = 0;
    localparam int K_MSHIFT = 1;
    localparam int K_AWR    = 2;
    localparam int K_SR     = 3;
    localparam int K_DMWR   = 4;
    localparam int K_AINC   = 5;
    localparam int K_FERR   = 6;
    localparam int K_MENUP  = 7;
    localparam int K_MENDN  = 8;

    localparam int PH_IDLE = 0;
    localparam int PH_HDR  = 1;
    localparam int PH_RD   = 2;
    localparam int PH_WR   = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_pin = 1'b0;
    logic cs_pin = 1'b1;
    logic mosi = 1'b0;

    logic [6:0] pl0, pl1;
    logic       men0, men1;
    logic       rw0, rw1;
    logic       pm0 = 1'b0, pm1 = 1'b0;
    logic [DATA_W-1:0] sr0 = '0, sr1 = '0;

    longint cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int     kind;
        longint cyc;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    int ph [2];
    int bits [2];
    bit men_m [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .BURST_EN(1)) u_burst (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .r_or_w(rw0),
        .shift_en(pl0[0]), .miso_shift(pl0[1]), .addr_wr(pl0[2]), .s_r(pl0[3]),
        .dm_wr(pl0[4]), .addr_inc(pl0[5]), .miso_en(men0), .frame_err(pl0[6])
    );

    spi_frame_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .BURST_EN(0)) u_single (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .r_or_w(rw1),
        .shift_en(pl1[0]), .miso_shift(pl1[1]), .addr_wr(pl1[2]), .s_r(pl1[3]),
        .dm_wr(pl1[4]), .addr_inc(pl1[5]), .miso_en(men1), .frame_err(pl1[6])
    );

    // External shift registers; r_or_w is their LSB.
    always @(posedge clk) begin
        if (pl0[0]) sr0 <= {sr0[DATA_W-2:0], mosi};
        if (pl1[0]) sr1 <= {sr1[DATA_W-2:0], mosi};
    end
    assign rw0 = sr0[0];
    assign rw1 = sr1[0];

    function automatic string kname(int k);
        case (k)
            K_SHIFT:  return "shift_en";
            K_MSHIFT: return "miso_shift";
            K_AWR:    return "addr_wr";
            K_SR:     return "s_r";
            K_DMWR:   return "dm_wr";
            K_AINC:   return "addr_inc";
            K_FERR:   return "frame_err";
            K_MENUP:  return "miso_en_rise";
            default:  return "miso_en_fall";
        endcase
    endfunction

    function automatic string iname(int i);
        return (i == 0) ? "burst" : "single";
    endfunction

    function automatic bit q_has(int i);
        return (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    endfunction

    function automatic ev_t q_front(int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    task automatic expect_ev(int i, int kind, longint c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_one(int i, logic [6:0] pl, logic men, logic pm);
        logic [8:0] ev;
        ev_t f;
        string nx;
        ev = {pm & ~men, ~pm & men, pl};
        for (int k = 0; k < 9; k++) begin
            if (ev[k]) begin
                n_cmp++;
                f.kind = -1;
                f.cyc  = -1;
                if (q_has(i)) f = q_front(i);
                if (f.cyc == cyc && f.kind == k) begin
                    q_pop(i);
                end else begin
                    n_bad++;
                    nx = q_has(i) ? $sformatf("%s@%0d", kname(f.kind), f.cyc) : "none";
                    $display("FAIL %s_%s: got strobe at cycle %0d, required next: %s",
                             iname(i), kname(k), cyc, nx);
                end
            end
        end
        while (q_has(i)) begin
            f = q_front(i);
            if (f.cyc > cyc) break;
            n_cmp++;
            n_bad++;
            $display("FAIL %s_%s: got no strobe, required at cycle %0d", iname(i), kname(f.kind), f.cyc);
            q_pop(i);
        end
    endtask

    always @(negedge clk) begin
        monitor_one(0, pl0, men0, pm0);
        monitor_one(1, pl1, men1, pm1);
        pm0 = men0;
        pm1 = men1;
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(string name, logic [6:0] pl, logic men);
        n_cmp++;
        if ({men, pl} !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: outputs {miso_en,strobes}=%b, required 00000000", name, {men, pl});
        end
    endtask

    task automatic sclk_rise(bit b);
        longint r;
        sclk_pin = 1'b1;
        mosi     = b;
        r        = cyc + SYNC_STAGES;
        for (int i = 0; i < 2; i++) begin
            case (ph[i])
                PH_HDR: begin
                    expect_ev(i, K_SHIFT, r + 1);
                    bits[i]++;
                    if (bits[i] == ADDR_W + 1) begin
                        expect_ev(i, K_AWR, r + 3);
                        bits[i] = 0;
                        if (b) begin
                            expect_ev(i, K_SR, r + 5);
                            expect_ev(i, K_MENUP, r + 5);
                            men_m[i] = 1'b1;
                            ph[i]    = PH_RD;
                        end else begin
                            ph[i] = PH_WR;
                        end
                    end
                end
                PH_WR: begin
                    expect_ev(i, K_SHIFT, r + 1);
                    bits[i]++;
                    if (bits[i] == DATA_W) begin
                        expect_ev(i, K_DMWR, r + 3);
                        if (i == 0) begin
                            expect_ev(i, K_AINC, r + 4);
                            bits[i] = 0;
                        end else begin
                            ph[i] = PH_DONE;
                        end
                    end
                end
                PH_RD: begin
                    expect_ev(i, K_SHIFT, r + 1);
                    bits[i]++;
                    if (bits[i] == DATA_W) begin
                        if (i == 0) begin
                            expect_ev(i, K_AINC, r + 2);
                            expect_ev(i, K_SR, r + 4);
                            bits[i] = 0;
                        end else begin
                            ph[i] = PH_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        tick(HALF);
    endtask

    task automatic sclk_fall();
        longint f;
        sclk_pin = 1'b0;
        f        = cyc + SYNC_STAGES;
        for (int i = 0; i < 2; i++) begin
            if (ph[i] == PH_RD && bits[i] >= 1 && bits[i] < DATA_W) expect_ev(i, K_MSHIFT, f + 1);
        end
        tick(HALF);
    endtask

    task automatic cs_fall();
        cs_pin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ph[i]   = PH_HDR;
            bits[i] = 0;
        end
        tick(HALF);
    endtask

    task automatic cs_rise();
        longint c;
        cs_pin = 1'b1;
        c      = cyc + SYNC_STAGES;
        for (int i = 0; i < 2; i++) begin
            if ((ph[i] == PH_HDR || ph[i] == PH_RD || ph[i] == PH_WR) && bits[i] != 0)
                expect_ev(i, K_FERR, c + 1);
            if (men_m[i]) expect_ev(i, K_MENDN, c + 1);
            ph[i]    = PH_IDLE;
            bits[i]  = 0;
            men_m[i] = 1'b0;
        end
        tick(HALF);
    endtask

    task automatic send_bits(logic [15:0] v, int n);
        for (int k = n - 1; k >= 0; k--) begin
            sclk_rise(v[k]);
            sclk_fall();
        end
    endtask

    task automatic header(logic [ADDR_W-1:0] a, bit rw);
        logic [15:0] v;
        v = '0;
        v[ADDR_W:0] = {a, rw};
        send_bits(v, ADDR_W + 1);
    endtask

    task automatic word(logic [DATA_W-1:0] d);
        logic [15:0] v;
        v = '0;
        v[DATA_W-1:0] = d;
        send_bits(v, DATA_W);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ph[i]    = PH_IDLE;
            bits[i]  = 0;
            men_m[i] = 1'b0;
        end

        // Power-on reset
        tick(4);
        @(negedge clk);
        chk_quiet("burst_reset", pl0, men0);
        chk_quiet("single_reset", pl1, men1);
        tick(1);
        rst_n = 1'b1;
        tick(HALF);

        // Single write: addr 0x15, data 0xA5
        cs_fall();
        header(7'h15, 1'b0);
        word(8'hA5);
        cs_rise();

        // Single read: addr 0x2A
        cs_fall();
        header(7'h2A, 1'b1);
        word(8'h00);
        cs_rise();

        // Burst write, 3 words
        cs_fall();
        header(7'h05, 1'b0);
        word(8'h11);
        word(8'h22);
        word(8'h33);
        cs_rise();

        // Burst read, 2 words
        cs_fall();
        header(7'h40, 1'b1);
        word(8'h00);
        word(8'h00);
        cs_rise();

        // Abort after 3 bits of a write word, then a clean frame
        cs_fall();
        header(7'h15, 1'b0);
        send_bits(16'h0005, 3);
        cs_rise();
        cs_fall();
        header(7'h2A, 1'b0);
        word(8'h5A);
        cs_rise();

        // Abort inside the header
        cs_fall();
        send_bits(16'h0005, 3);
        cs_rise();

        // CS pulse with no sclk
        cs_fall();
        tick(HALF);
        cs_rise();

        // Reset in the middle of a write word, then a full write frame
        cs_fall();
        header(7'h15, 1'b0);
        send_bits(16'h0006, 3);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ph[i]    = PH_IDLE;
            bits[i]  = 0;
            men_m[i] = 1'b0;
        end
        tick(2);
        @(negedge clk);
        chk_quiet("burst_reset_mid_frame", pl0, men0);
        chk_quiet("single_reset_mid_frame", pl1, men1);
        tick(1);
        cs_pin = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(HALF);
        cs_fall();
        header(7'h15, 1'b0);
        word(8'hA5);
        cs_rise();

        tick(2 * HALF);
        @(negedge clk);
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d expected strobes left, required 0", q0.size() + q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
